// File: rtl/dt_res_packer_if.sv
// dt_res_packer_if: control, res RAM read port and sti RAM write port of the
// distance-transform result packer, bundled as one interface.
interface dt_res_packer_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di;
    logic        sti_wr;
    logic [9:0]  sti_addr;
    logic [15:0] sti_do;
    logic [14:0] set_cnt;

    // Packer side: consumes start and read data, drives everything else.
    modport master (
        input  start,
        input  res_di,
        output busy,
        output done,
        output res_rd,
        output res_addr,
        output sti_wr,
        output sti_addr,
        output sti_do,
        output set_cnt
    );

    // Environment side: issues start, serves the res RAM, absorbs the writes.
    modport slave (
        output start,
        output res_di,
        input  busy,
        input  done,
        input  res_rd,
        input  res_addr,
        input  sti_wr,
        input  sti_addr,
        input  sti_do,
        input  set_cnt
    );
endinterface

// File: rtl/dt_res_packer.sv
// dt_res_packer: streams all 16384 8-bit distance values out of the res RAM,
// thresholds each to one bit, packs 16 pixels per word and writes the 1024
// words to a sti-format RAM while counting set pixels.
module dt_res_packer #(
    parameter logic [7:0] THRESH    = 8'd1,
    parameter bit         MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    dt_res_packer_if.master bus
);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, FLUSH, DONE} state_t;

    localparam logic [13:0] LAST_ADDR = 14'h3FFF;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        res_rd_q, res_rd_d;
    logic [13:0] res_addr_q, res_addr_d;
    logic        sti_wr_q, sti_wr_d;
    logic [9:0]  sti_addr_q, sti_addr_d;
    logic [15:0] sti_do_q, sti_do_d;
    logic [14:0] set_cnt_q, set_cnt_d;
    // pend_q: res_di carries the pixel read one cycle earlier and must be captured now
    logic        pend_q, pend_d;
    logic [13:0] pix_q, pix_d;
    logic [15:0] shift_q, shift_d;
    logic        pix_bit;
    logic [15:0] shift_in;

    // Next-state logic: address sequencing, capture/pack pipeline and word writes
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = done_q;
        res_rd_d   = res_rd_q;
        res_addr_d = res_addr_q;
        sti_wr_d   = 1'b0;
        sti_addr_d = sti_addr_q;
        sti_do_d   = sti_do_q;
        set_cnt_d  = set_cnt_q;
        shift_d    = shift_q;
        pix_d      = pix_q;
        pend_d     = res_rd_q;

        pix_bit  = (bus.res_di >= THRESH);
        shift_in = MSB_FIRST ? {shift_q[14:0], pix_bit} : {pix_bit, shift_q[15:1]};

        // The word is complete once its 16th pixel is shifted in; the write
        // shows the freshly shifted value so no extra cycle is spent.
        if (pend_q) begin
            shift_d   = shift_in;
            pix_d     = pix_q + 14'd1;
            set_cnt_d = set_cnt_q + {14'd0, pix_bit};
            if (pix_q[3:0] == 4'hF) begin
                sti_wr_d   = 1'b1;
                sti_addr_d = pix_q[13:4];
                sti_do_d   = shift_in;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    res_rd_d   = 1'b1;
                    res_addr_d = 14'd0;
                    set_cnt_d  = 15'd0;
                    shift_d    = 16'd0;
                    pix_d      = 14'd0;
                end
            end
            RUN: begin
                if (res_addr_q == LAST_ADDR) begin
                    state_d  = DRAIN;
                    res_rd_d = 1'b0;
                end else begin
                    res_addr_d = res_addr_q + 14'd1;
                end
            end
            DRAIN: begin
                state_d = FLUSH;
            end
            FLUSH: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset takes effect immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            res_rd_q   <= 1'b0;
            res_addr_q <= 14'd0;
            sti_wr_q   <= 1'b0;
            sti_addr_q <= 10'd0;
            sti_do_q   <= 16'd0;
            set_cnt_q  <= 15'd0;
            pend_q     <= 1'b0;
            pix_q      <= 14'd0;
            shift_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            res_rd_q   <= res_rd_d;
            res_addr_q <= res_addr_d;
            sti_wr_q   <= sti_wr_d;
            sti_addr_q <= sti_addr_d;
            sti_do_q   <= sti_do_d;
            set_cnt_q  <= set_cnt_d;
            pend_q     <= pend_d;
            pix_q      <= pix_d;
            shift_q    <= shift_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.res_rd   = res_rd_q;
    assign bus.res_addr = res_addr_q;
    assign bus.sti_wr   = sti_wr_q;
    assign bus.sti_addr = sti_addr_q;
    assign bus.sti_do   = sti_do_q;
    assign bus.set_cnt  = set_cnt_q;
endmodule

// File: tb/tb_dt_res_packer.sv
// tb_dt_res_packer: three packer instances (THRESH=1 MSB-first, THRESH=1
// LSB-first, THRESH=64 MSB-first) read the same res image; every write,
// control output and the final count are compared against a pixel-level
// reference computed directly from the image.
`timescale 1ns/1ps
module tb_dt_res_packer;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic reset;
    logic start;
    always #5 clk = ~clk;

    dt_res_packer_if bus [NDUT] ();

    logic [7:0]  mem [16384];
    logic [15:0] img [1024];

    logic [NDUT-1:0] wr_v, rd_v, busy_v, done_v;
    logic [9:0]  waddr_v [NDUT];
    logic [15:0] wdata_v [NDUT];
    logic [13:0] raddr_v [NDUT];
    logic [14:0] cnt_v   [NDUT];

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam logic [7:0] TH  = (gi == 2) ? 8'd64 : 8'd1;
            localparam bit         MSB = (gi == 1) ? 1'b0 : 1'b1;

            assign bus[gi].start = start;

            dt_res_packer #(.THRESH(TH), .MSB_FIRST(MSB)) u_dut (
                .clk   (clk),
                .reset (reset),
                .bus   (bus[gi])
            );

            // res RAM with registered read; garbage when not read
            always @(posedge clk) begin
                if (bus[gi].res_rd) bus[gi].res_di <= mem[bus[gi].res_addr];
                else                bus[gi].res_di <= 8'($urandom);
            end

            assign wr_v[gi]    = bus[gi].sti_wr;
            assign rd_v[gi]    = bus[gi].res_rd;
            assign busy_v[gi]  = bus[gi].busy;
            assign done_v[gi]  = bus[gi].done;
            assign waddr_v[gi] = bus[gi].sti_addr;
            assign wdata_v[gi] = bus[gi].sti_do;
            assign raddr_v[gi] = bus[gi].res_addr;
            assign cnt_v[gi]   = bus[gi].set_cnt;
        end
    endgenerate

    // ---------------- reference model ----------------
    function automatic logic [7:0] th_of(int k);
        return (k == 2) ? 8'd64 : 8'd1;
    endfunction

    function automatic bit msb_of(int k);
        return (k != 1);
    endfunction

    function automatic logic [15:0] model_word(int k, int w);
        logic [15:0] r;
        r = 16'd0;
        for (int i = 0; i < 16; i++)
            if (mem[16*w + i] >= th_of(k)) r[msb_of(k) ? 15 - i : i] = 1'b1;
        return r;
    endfunction

    function automatic int model_count(int k);
        int c;
        c = 0;
        for (int a = 0; a < 16384; a++)
            if (mem[a] >= th_of(k)) c++;
        return c;
    endfunction

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int clk_cnt  = 0;
    int start_cnt = 0;
    bit mon_en = 1'b0;

    int wr_n [NDUT];
    int bad_n [NDUT];
    int ctl_n [NDUT];
    int done_cyc [NDUT];
    int tot_wr [NDUT];
    logic [15:0] w0_v [NDUT];
    logic [15:0] wl_v [NDUT];

    initial forever begin
        @(posedge clk);
        clk_cnt++;
    end

    // Cycle-accurate monitor: cycle 0 is the cycle in which start is high
    initial begin
        int  cyc;
        bit  exp_rd, exp_busy, exp_done;
        for (int k = 0; k < NDUT; k++) begin
            wr_n[k] = 0; bad_n[k] = 0; ctl_n[k] = 0; done_cyc[k] = -1; tot_wr[k] = 0;
            w0_v[k] = 16'd0; wl_v[k] = 16'd0;
        end
        forever begin
            @(negedge clk);
            cyc = clk_cnt - start_cnt;
            for (int k = 0; k < NDUT; k++) begin
                if (wr_v[k]) tot_wr[k]++;
                if (mon_en) begin
                    if (cyc == 0) begin
                        wr_n[k] = 0; bad_n[k] = 0; ctl_n[k] = 0; done_cyc[k] = -1;
                    end else begin
                        if (wr_v[k]) begin
                            if (wr_n[k] > 1023 || cyc != 16*wr_n[k] + 18 ||
                                waddr_v[k] != 10'(wr_n[k]) ||
                                wdata_v[k] != model_word(k, wr_n[k])) begin
                                if (bad_n[k] == 0)
                                    $display("first bad write: dut%0d cycle %0d addr %0d data 0x%04h (write #%0d)",
                                             k, cyc, waddr_v[k], wdata_v[k], wr_n[k]);
                                bad_n[k]++;
                            end
                            if (wr_n[k] == 0) w0_v[k] = wdata_v[k];
                            wl_v[k] = wdata_v[k];
                            wr_n[k]++;
                        end
                        exp_rd   = (cyc <= 16384);
                        exp_busy = (cyc <= 16386);
                        exp_done = (cyc >= 16387);
                        if (rd_v[k] !== exp_rd || busy_v[k] !== exp_busy || done_v[k] !== exp_done ||
                            (exp_rd && raddr_v[k] != 14'(cyc - 1))) begin
                            if (ctl_n[k] == 0)
                                $display("first bad control: dut%0d cycle %0d rd=%0b addr=%0d busy=%0b done=%0b",
                                         k, cyc, rd_v[k], raddr_v[k], busy_v[k], done_v[k]);
                            ctl_n[k]++;
                        end
                        if (done_v[k] && done_cyc[k] < 0) done_cyc[k] = cyc;
                    end
                end
            end
        end
    end

    task automatic check(string name, int k, int got, int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d got=%0d (0x%0h) want=%0d (0x%0h)", name, k, got, got, exp, exp);
        end
    endtask

    function automatic int outs_or(int k);
        return int'(raddr_v[k]) | int'(waddr_v[k]) | int'(wdata_v[k]) | int'(cnt_v[k]) |
               int'({rd_v[k], busy_v[k], done_v[k], wr_v[k]});
    endfunction

    task automatic load_pattern(int p);
        for (int w = 0; w < 1024; w++) img[w] = 16'($urandom);
        for (int a = 0; a < 16384; a++) begin
            case (p)
                0:       mem[a] = 8'd0;
                1:       mem[a] = (a == 0) ? 8'd5 : 8'd0;
                2:       mem[a] = 8'(a & 127);
                default: mem[a] = img[a / 16][15 - (a % 16)] ? 8'($urandom_range(1, 255)) : 8'd0;
            endcase
        end
    endtask

    task automatic do_start();
        @(posedge clk); #2;
        start = 1'b1;
        start_cnt = clk_cnt;
        mon_en = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // Full pass; optional extra start pulse at cycle pulse_at while busy
    task automatic run_pass(int pulse_at);
        do_start();
        if (pulse_at > 1) begin
            repeat (pulse_at - 1) @(posedge clk);
            #2 start = 1'b1;
            @(posedge clk);
            #2 start = 1'b0;
        end
        while (clk_cnt - start_cnt < 16392) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic check_pass(string tag);
        for (int k = 0; k < NDUT; k++) begin
            check({tag, ":write_count"}, k, wr_n[k], 1024);
            check({tag, ":bad_writes"},  k, bad_n[k], 0);
            check({tag, ":ctl_errors"},  k, ctl_n[k], 0);
            check({tag, ":done_cycle"},  k, done_cyc[k], 16387);
            check({tag, ":set_cnt"},     k, int'(cnt_v[k]), model_count(k));
            $display("pass %s dut%0d: writes=%0d set_cnt=%0d done@%0d word0=0x%04h word1023=0x%04h",
                     tag, k, wr_n[k], cnt_v[k], done_cyc[k], w0_v[k], wl_v[k]);
        end
    endtask

    typedef struct {
        int                pat;
        logic [2:0][14:0]  cnt;
        logic [2:0][15:0]  w0;
        logic [2:0][15:0]  wl;
    } vec_t;

    vec_t tbl [3];
    int   snap [NDUT];

    initial begin
        // index order inside {}: dut2, dut1, dut0
        tbl[0].pat = 0;
        tbl[0].cnt = {15'd0, 15'd0, 15'd0};
        tbl[0].w0  = {16'h0000, 16'h0000, 16'h0000};
        tbl[0].wl  = {16'h0000, 16'h0000, 16'h0000};
        tbl[1].pat = 1;
        tbl[1].cnt = {15'd0, 15'd1, 15'd1};
        tbl[1].w0  = {16'h0000, 16'h0001, 16'h8000};
        tbl[1].wl  = {16'h0000, 16'h0000, 16'h0000};
        tbl[2].pat = 2;
        tbl[2].cnt = {15'd8192, 15'd16256, 15'd16256};
        tbl[2].w0  = {16'h0000, 16'hFFFE, 16'h7FFF};
        tbl[2].wl  = {16'hFFFF, 16'hFFFF, 16'hFFFF};

        reset = 1'b1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        for (int k = 0; k < NDUT; k++) check("reset_outputs", k, outs_or(k), 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < NDUT; k++) check("idle_outputs", k, outs_or(k), 0);

        // Table-driven directed images
        for (int v = 0; v < 3; v++) begin
            load_pattern(tbl[v].pat);
            run_pass(0);
            check_pass($sformatf("pattern%0d", tbl[v].pat));
            for (int k = 0; k < NDUT; k++) begin
                check("table_set_cnt", k, int'(cnt_v[k]), int'(tbl[v].cnt[k]));
                check("table_word0",   k, int'(w0_v[k]),  int'(tbl[v].w0[k]));
                check("table_word1023", k, int'(wl_v[k]), int'(tbl[v].wl[k]));
            end
        end

        // Random round-trip image; asynchronous reset at cycle 3000
        load_pattern(3);
        do_start();
        repeat (2999) @(posedge clk);
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("midrun_reset_outputs", k, outs_or(k), 0);
            check("writes_before_reset",  k, wr_n[k], 187);
            check("bad_before_reset",     k, bad_n[k] + ctl_n[k], 0);
            snap[k] = tot_wr[k];
        end
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        for (int k = 0; k < NDUT; k++) check("writes_after_reset", k, tot_wr[k] - snap[k], 0);
        $display("reset at cycle 3000: outputs cleared, no writes in the following 43 cycles");

        // Fresh full pass of the same image, with an ignored start at cycle 500
        run_pass(500);
        check_pass("roundtrip");
        check("roundtrip_word0",    0, int'(w0_v[0]), int'(img[0]));
        check("roundtrip_word1023", 0, int'(wl_v[0]), int'(img[1023]));
        begin
            int ones;
            ones = 0;
            for (int w = 0; w < 1024; w++) ones += $countones(img[w]);
            check("roundtrip_popcount", 0, int'(cnt_v[0]), ones);
            check("roundtrip_popcount", 1, int'(cnt_v[1]), ones);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
